cpu_int_acknowledge: RTL and testbench

- CPU-side receiver of the active-low 3-bit interrupt priority request from the Paula interrupt controller.
- Filters the priority inputs and decides, against the CPU status-register mask, when an interrupt is pending.
- Runs the interrupt-acknowledge handshake with the CPU core and returns the autovector number plus the new mask level.
- Sits between Paula and the 68k core wrapper in the CPU clock domain, gated by the 7 MHz enable.

---
 rtl/cpu_int_acknowledge_pkg.sv | 19 +
 rtl/cpu_int_acknowledge_ipl_filter.sv | 53 +++++
 rtl/cpu_int_acknowledge.sv | 155 +++++++++++++++
 tb/tb_cpu_int_acknowledge.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_int_acknowledge_pkg.sv
// Shared definitions for the CPU interrupt-acknowledge block.
//   IPL_NONE         : idle value of the active-low priority request
//   AUTOVEC_BASE_DEF : default autovector number for level 0 (spurious)
//   LVL_W            : width of an interrupt level
//   state_t          : acknowledge FSM encoding
package cpu_int_acknowledge_pkg;

   localparam int          LVL_W            = 3;
   localparam logic [2:0]  IPL_NONE         = 3'b111;
   localparam logic [7:0]  AUTOVEC_BASE_DEF = 8'd24;
   localparam logic [2:0]  LVL_NMI          = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACK  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/cpu_int_acknowledge_ipl_filter.sv
// Two-stage sampler and equality filter for the active-low IPL request,
// plus the level-7 (NMI) edge latch.
//   clk, _reset, clk7_en : clock, async active-low reset, 7 MHz enable
//   i_ipl                : raw active-low priority request
//   i_nmi_clr            : clear the NMI latch (level-7 interrupt taken)
//   o_stable_level       : filtered active-high level
//   o_nmi_pend           : NMI latched, or an NMI edge seen this tick
module cpu_int_acknowledge_ipl_filter
   import cpu_int_acknowledge_pkg::*;
(
   input  logic             clk,
   input  logic             _reset,
   input  logic             clk7_en,
   input  logic [LVL_W-1:0] i_ipl,
   input  logic             i_nmi_clr,
   output logic [LVL_W-1:0] o_stable_level,
   output logic             o_nmi_pend
);

   logic [LVL_W-1:0] r_s1;
   logic [LVL_W-1:0] r_s0;
   logic [LVL_W-1:0] r_hold;
   logic             r_nmi;
   logic [LVL_W-1:0] w_stable;
   logic             w_nmi_edge;

   // The stable level follows the samples as soon as both stages agree and
   // otherwise holds the last agreed value, so a one-tick glitch never lands.
   assign w_stable   = (r_s0 == r_s1) ? ~r_s0 : r_hold;
   assign w_nmi_edge = (w_stable == LVL_NMI) && (r_hold != LVL_NMI);

   always_ff @(posedge clk or negedge _reset) begin
      if (!_reset) begin
         r_s1   <= IPL_NONE;
         r_s0   <= IPL_NONE;
         r_hold <= '0;
         r_nmi  <= 1'b0;
      end else if (clk7_en) begin
         r_s1   <= i_ipl;
         r_s0   <= r_s1;
         r_hold <= w_stable;
         // A fresh edge beats a clear on the same tick: it is a new NMI.
         if (w_nmi_edge)
            r_nmi <= 1'b1;
         else if (i_nmi_clr)
            r_nmi <= 1'b0;
      end
   end

   assign o_stable_level = w_stable;
   assign o_nmi_pend     = r_nmi | w_nmi_edge;

endmodule

// File: rtl/cpu_int_acknowledge.sv
// CPU-side interrupt receiver: filters Paula's IPL request, offers pending
// interrupts to the core against the SR mask and runs the IACK cycle that
// returns the autovector and new mask level.
//   clk, _reset, clk7_en : clock, async active-low reset, 7 MHz enable
//   _ipl, sr_mask        : active-low request, current SR interrupt mask
//   int_take             : core accepts the offered interrupt
//   int_req, int_level   : interrupt offered to the core
//   ack_busy             : IACK cycle in progress
//   vec_valid, vector, new_mask, spurious : one-tick acknowledge result
//
// state   | meaning
// IDLE    | evaluate pending level, offer it, wait for int_take
// ACK     | IACK cycle, counting ACK_TICKS enable ticks
// DONE    | result presented for one tick, then back to IDLE
module cpu_int_acknowledge
   import cpu_int_acknowledge_pkg::*;
#(
   parameter int         ACK_TICKS    = 4,
   parameter logic [7:0] AUTOVEC_BASE = AUTOVEC_BASE_DEF
)(
   input  logic       clk,
   input  logic       _reset,
   input  logic       clk7_en,
   input  logic [2:0] _ipl,
   input  logic [2:0] sr_mask,
   input  logic       int_take,
   output logic       int_req,
   output logic [2:0] int_level,
   output logic       ack_busy,
   output logic       vec_valid,
   output logic [7:0] vector,
   output logic [2:0] new_mask,
   output logic       spurious
);

   state_t           r_state, w_state_nxt;
   logic [3:0]       r_cnt, w_cnt_nxt;
   logic [LVL_W-1:0] r_lvl, w_lvl_nxt;
   logic             r_int_req, w_int_req_nxt;
   logic [LVL_W-1:0] r_int_level, w_int_level_nxt;
   logic             r_ack_busy, w_ack_busy_nxt;
   logic             r_vec_valid, w_vec_valid_nxt;
   logic [7:0]       r_vector, w_vector_nxt;
   logic [LVL_W-1:0] r_new_mask, w_new_mask_nxt;
   logic             r_spurious, w_spurious_nxt;
   logic             w_nmi_clr;
   logic [LVL_W-1:0] w_stable;
   logic             w_nmi_pend;
   logic [LVL_W-1:0] w_pend;

   cpu_int_acknowledge_ipl_filter u_ipl_filter (
      .clk            (clk),
      ._reset         (_reset),
      .clk7_en        (clk7_en),
      .i_ipl          (_ipl),
      .i_nmi_clr      (w_nmi_clr),
      .o_stable_level (w_stable),
      .o_nmi_pend     (w_nmi_pend)
   );

   // NMI is offered even when the mask is 7.
   assign w_pend = w_nmi_pend           ? LVL_NMI  :
                   (w_stable > sr_mask) ? w_stable : '0;

   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_lvl_nxt       = r_lvl;
      w_int_req_nxt   = r_int_req;
      w_int_level_nxt = r_int_level;
      w_ack_busy_nxt  = r_ack_busy;
      w_vec_valid_nxt = 1'b0;
      w_vector_nxt    = r_vector;
      w_new_mask_nxt  = r_new_mask;
      w_spurious_nxt  = r_spurious;
      w_nmi_clr       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // Take uses the level already offered, not this tick's pending value.
            if (int_take && r_int_req) begin
               w_state_nxt     = ST_ACK;
               w_lvl_nxt       = r_int_level;
               w_cnt_nxt       = 4'(ACK_TICKS - 1);
               w_int_req_nxt   = 1'b0;
               w_int_level_nxt = '0;
               w_ack_busy_nxt  = 1'b1;
               w_nmi_clr       = (r_int_level == LVL_NMI);
            end else begin
               w_int_req_nxt   = (w_pend != '0);
               w_int_level_nxt = w_pend;
            end
         end
         ST_ACK: begin
            if (r_cnt == 4'd0) begin
               w_state_nxt     = ST_DONE;
               w_ack_busy_nxt  = 1'b0;
               w_vec_valid_nxt = 1'b1;
               w_new_mask_nxt  = r_lvl;
               if (w_stable == '0) begin
                  w_vector_nxt   = AUTOVEC_BASE;
                  w_spurious_nxt = 1'b1;
               end else begin
                  w_vector_nxt   = AUTOVEC_BASE + {5'b0, r_lvl};
                  w_spurious_nxt = 1'b0;
               end
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt    = ST_IDLE;
            w_ack_busy_nxt = 1'b0;
            w_int_req_nxt  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge _reset) begin
      if (!_reset) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_lvl       <= '0;
         r_int_req   <= 1'b0;
         r_int_level <= '0;
         r_ack_busy  <= 1'b0;
         r_vec_valid <= 1'b0;
         r_vector    <= '0;
         r_new_mask  <= '0;
         r_spurious  <= 1'b0;
      end else if (clk7_en) begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_lvl       <= w_lvl_nxt;
         r_int_req   <= w_int_req_nxt;
         r_int_level <= w_int_level_nxt;
         r_ack_busy  <= w_ack_busy_nxt;
         r_vec_valid <= w_vec_valid_nxt;
         r_vector    <= w_vector_nxt;
         r_new_mask  <= w_new_mask_nxt;
         r_spurious  <= w_spurious_nxt;
      end
   end

   assign int_req   = r_int_req;
   assign int_level = r_int_level;
   assign ack_busy  = r_ack_busy;
   assign vec_valid = r_vec_valid;
   assign vector    = r_vector;
   assign new_mask  = r_new_mask;
   assign spurious  = r_spurious;

endmodule

// File: tb/tb_cpu_int_acknowledge.sv
module tb_cpu_int_acknowledge;

   logic       clk = 1'b0;
   logic       _reset = 1'b0;
   logic       clk7_en = 1'b0;
   logic [2:0] _ipl = 3'b111;
   logic [2:0] sr_mask = 3'd0;
   logic       int_take = 1'b0;
   logic       int_req;
   logic [2:0] int_level;
   logic       ack_busy;
   logic       vec_valid;
   logic [7:0] vector;
   logic [2:0] new_mask;
   logic       spurious;

   int n_cmp = 0;
   int n_err = 0;

   cpu_int_acknowledge #(.ACK_TICKS(4), .AUTOVEC_BASE(8'd24)) dut (
      .clk       (clk),
      ._reset    (_reset),
      .clk7_en   (clk7_en),
      ._ipl      (_ipl),
      .sr_mask   (sr_mask),
      .int_take  (int_take),
      .int_req   (int_req),
      .int_level (int_level),
      .ack_busy  (ack_busy),
      .vec_valid (vec_valid),
      .vector    (vector),
      .new_mask  (new_mask),
      .spurious  (spurious)
   );

   always #5 clk = ~clk;

   // One enable tick followed by one disabled clock, so gating is exercised.
   task automatic tick();
      @(negedge clk);
      clk7_en = 1'b1;
      @(posedge clk);
      #1 clk7_en = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic take();
      int_take = 1'b1;
      tick();
      int_take = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      n_cmp++;
      if ({int_req, int_level, ack_busy, vec_valid, vector, new_mask, spurious} !== 18'd0) begin
         n_err++;
         $display("FAIL reset_outs: got req=%0b lvl=%0d busy=%0b vv=%0b vec=%0d nm=%0d sp=%0b want all 0",
                  int_req, int_level, ack_busy, vec_valid, vector, new_mask, spurious);
      end
      @(negedge clk);
      _reset = 1'b1;
      ticks(2);
   endtask

   task automatic test_glitch();
      sr_mask = 3'd0;
      _ipl = 3'b101;
      tick();
      _ipl = 3'b111;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_cmp++;
         if (int_req !== 1'b0) begin
            n_err++;
            $display("FAIL glitch_req tick%0d: got %0b want 0", i, int_req);
         end
      end
   endtask

   task automatic test_normal();
      sr_mask = 3'd0;
      _ipl = 3'b101;
      tick();
      n_cmp++;
      if (int_req !== 1'b0) begin
         n_err++; $display("FAIL norm_early: got %0b want 0", int_req);
      end
      ticks(2);
      n_cmp++;
      if (int_req !== 1'b1 || int_level !== 3'd2) begin
         n_err++; $display("FAIL norm_req: got req=%0b lvl=%0d want req=1 lvl=2", int_req, int_level);
      end
      take();
      n_cmp++;
      if (int_req !== 1'b0) begin
         n_err++; $display("FAIL norm_req_drop: got %0b want 0", int_req);
      end
      for (int i = 0; i < 4; i++) begin
         if (i > 0) tick();
         n_cmp++;
         if (ack_busy !== 1'b1 || vec_valid !== 1'b0) begin
            n_err++; $display("FAIL norm_busy%0d: got busy=%0b vv=%0b want 1/0", i, ack_busy, vec_valid);
         end
      end
      tick();
      n_cmp++;
      if (vec_valid !== 1'b1 || ack_busy !== 1'b0 || vector !== 8'd26 || new_mask !== 3'd2 || spurious !== 1'b0) begin
         n_err++;
         $display("FAIL norm_vec: got vv=%0b busy=%0b vec=%0d nm=%0d sp=%0b want 1/0/26/2/0",
                  vec_valid, ack_busy, vector, new_mask, spurious);
      end
      sr_mask = 3'd2;
      tick();
      n_cmp++;
      if (vec_valid !== 1'b0) begin
         n_err++; $display("FAIL norm_vv_fall: got %0b want 0", vec_valid);
      end
      ticks(2);
      n_cmp++;
      if (int_req !== 1'b0) begin
         n_err++; $display("FAIL norm_masked_after: got %0b want 0", int_req);
      end
      _ipl = 3'b111;
      sr_mask = 3'd0;
      ticks(3);
   endtask

   task automatic test_masking();
      _ipl = 3'b100;
      sr_mask = 3'd3;
      ticks(4);
      n_cmp++;
      if (int_req !== 1'b0) begin
         n_err++; $display("FAIL mask_hold: got %0b want 0", int_req);
      end
      take();
      n_cmp++;
      if (ack_busy !== 1'b0) begin
         n_err++; $display("FAIL mask_take_ignored: got busy=%0b want 0", ack_busy);
      end
      sr_mask = 3'd2;
      tick();
      n_cmp++;
      if (int_req !== 1'b1 || int_level !== 3'd3) begin
         n_err++; $display("FAIL mask_unmask: got req=%0b lvl=%0d want 1/3", int_req, int_level);
      end
      sr_mask = 3'd7;
      tick();
      n_cmp++;
      if (int_req !== 1'b0) begin
         n_err++; $display("FAIL mask_remask: got %0b want 0", int_req);
      end
      _ipl = 3'b111;
      sr_mask = 3'd0;
      ticks(3);
   endtask

   task automatic test_nmi();
      sr_mask = 3'd7;
      _ipl = 3'b000;
      ticks(3);
      n_cmp++;
      if (int_req !== 1'b1 || int_level !== 3'd7) begin
         n_err++; $display("FAIL nmi_req: got req=%0b lvl=%0d want 1/7", int_req, int_level);
      end
      take();
      ticks(4);
      n_cmp++;
      if (vec_valid !== 1'b1 || vector !== 8'd31 || new_mask !== 3'd7 || spurious !== 1'b0) begin
         n_err++;
         $display("FAIL nmi_vec: got vv=%0b vec=%0d nm=%0d sp=%0b want 1/31/7/0", vec_valid, vector, new_mask, spurious);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         n_cmp++;
         if (int_req !== 1'b0) begin
            n_err++; $display("FAIL nmi_no_rereq%0d: got %0b want 0", i, int_req);
         end
      end
      _ipl = 3'b111;
      ticks(3);
      _ipl = 3'b000;
      ticks(3);
      n_cmp++;
      if (int_req !== 1'b1 || int_level !== 3'd7) begin
         n_err++; $display("FAIL nmi_second: got req=%0b lvl=%0d want 1/7", int_req, int_level);
      end
      // Take it and drop the request during ACK: spurious at level 7.
      take();
      _ipl = 3'b111;
      ticks(4);
      n_cmp++;
      if (vec_valid !== 1'b1 || vector !== 8'd24 || new_mask !== 3'd7 || spurious !== 1'b1) begin
         n_err++;
         $display("FAIL nmi_spur: got vv=%0b vec=%0d nm=%0d sp=%0b want 1/24/7/1", vec_valid, vector, new_mask, spurious);
      end
      sr_mask = 3'd0;
      ticks(3);
   endtask

   task automatic test_spurious();
      sr_mask = 3'd0;
      _ipl = 3'b011;
      ticks(3);
      n_cmp++;
      if (int_req !== 1'b1 || int_level !== 3'd4) begin
         n_err++; $display("FAIL spur_req: got req=%0b lvl=%0d want 1/4", int_req, int_level);
      end
      take();
      _ipl = 3'b111;
      ticks(3);
      n_cmp++;
      if (vec_valid !== 1'b0 || ack_busy !== 1'b1) begin
         n_err++; $display("FAIL spur_busy: got vv=%0b busy=%0b want 0/1", vec_valid, ack_busy);
      end
      tick();
      n_cmp++;
      if (vec_valid !== 1'b1 || vector !== 8'd24 || new_mask !== 3'd4 || spurious !== 1'b1) begin
         n_err++;
         $display("FAIL spur_vec: got vv=%0b vec=%0d nm=%0d sp=%0b want 1/24/4/1", vec_valid, vector, new_mask, spurious);
      end
      ticks(3);
   endtask

   task automatic test_reset_mid_ack();
      _ipl = 3'b110;
      ticks(3);
      take();
      ticks(2);
      n_cmp++;
      if (ack_busy !== 1'b1) begin
         n_err++; $display("FAIL rst_pre_busy: got %0b want 1", ack_busy);
      end
      _reset = 1'b0;
      _ipl = 3'b111;
      #1;
      n_cmp++;
      if ({int_req, int_level, ack_busy, vec_valid, vector, new_mask, spurious} !== 18'd0) begin
         n_err++;
         $display("FAIL rst_mid_outs: got req=%0b lvl=%0d busy=%0b vv=%0b vec=%0d nm=%0d sp=%0b want all 0",
                  int_req, int_level, ack_busy, vec_valid, vector, new_mask, spurious);
      end
      @(negedge clk);
      @(negedge clk);
      _reset = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         n_cmp++;
         if (vec_valid !== 1'b0 || ack_busy !== 1'b0 || int_req !== 1'b0) begin
            n_err++;
            $display("FAIL rst_after%0d: got vv=%0b busy=%0b req=%0b want 0/0/0", i, vec_valid, ack_busy, int_req);
         end
      end
      _ipl = 3'b110;
      ticks(3);
      n_cmp++;
      if (int_req !== 1'b1 || int_level !== 3'd1) begin
         n_err++; $display("FAIL rst_idle_req: got req=%0b lvl=%0d want 1/1", int_req, int_level);
      end
   endtask

   initial begin
      test_reset();
      test_glitch();
      test_normal();
      test_masking();
      test_nmi();
      test_spurious();
      test_reset_mid_ack();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
